// File: rtl/sico_reset_seq.sv
// sico_reset_seq: staged reset sequencer.
// After rst_i falls (through a deassertion synchronizer) the NUM_STAGES reset
// domains are released one at a time, STAGE_DELAY cycles apart, in ascending
// order. Once every stage is out of reset the block sits in RUN. A four-phase
// soft-reset handshake then re-asserts every stage and replays the release.
module sico_reset_seq #(
  parameter int NUM_STAGES  = 4,   // 1..8
  parameter int STAGE_DELAY = 16,  // 1..65535
  parameter int SYNC_DEPTH  = 2    // 2..4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_rst_req_i,
  output logic                  soft_rst_ack_o,
  output logic [NUM_STAGES-1:0] rst_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

  // The counter only ever has to reach STAGE_DELAY-1, but it is sized for
  // STAGE_DELAY itself so that no legal parameter value can make it wrap.
  localparam int CNT_W = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY + 1) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  // Pattern held by the stage register just before the final release.
  localparam logic [NUM_STAGES-1:0] LAST_MASK = NUM_STAGES'(1) << (NUM_STAGES - 1);

  localparam logic [1:0] ST_SYNC    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_SOFT    = 2'd3;

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_out;
  logic                  sync_falling;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stages_q, stages_d;
  logic                  done_q, done_d;
  logic                  ack_q, ack_d;

  // Reset deassertion synchronizer: presets on rst_i, then shifts zeros in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      // NOTE: clocked state is always updated with <= so every flop samples
      // pre-edge values, independent of the order of statements or blocks.
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b0};
    end
  end

  // sync_out is the synchronizer output. sync_falling is the value the output
  // flop captures on the coming edge: decoding it lets the FSM leave SYNC on
  // the very edge the output clears, i.e. SYNC_DEPTH edges after rst_i falls.
  assign sync_out     = sync_q[SYNC_DEPTH-1];
  assign sync_falling = ~sync_q[SYNC_DEPTH-2];

  // Next-state logic for the sequencer FSM, delay counter and stage resets.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    stages_d = stages_q;
    done_d   = done_q;
    ack_d    = ack_q;

    if ((state_q != ST_SYNC) && sync_out) begin
      // Synchronizer output can only be high outside SYNC if the state
      // register was disturbed; fall back to a full restart.
      state_d  = ST_SYNC;
      cnt_d    = '0;
      stages_d = '1;
      done_d   = 1'b0;
      ack_d    = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (sync_falling) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end
        end

        ST_RELEASE: begin
          if (cnt_q == CNT_LAST) begin
            // Release the lowest still-asserted stage. Shifting left drops
            // stages strictly in ascending order, so stage k+1 can never
            // leave reset while stage k is still held.
            cnt_d    = '0;
            stages_d = stages_q << 1;
            if (stages_q == LAST_MASK) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_RUN: begin
          // Soft-reset requests are only looked at here; a request raised
          // earlier simply waits until the sequence completes.
          if (soft_rst_req_i) begin
            state_d  = ST_SOFT;
            stages_d = '1;
            done_d   = 1'b0;
            ack_d    = 1'b1;
          end
        end

        ST_SOFT: begin
          // Hold every stage until the requester drops its request, then
          // drop the acknowledge and replay the release sequence.
          if (!soft_rst_req_i) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            ack_d   = 1'b0;
          end
        end

        default: begin
          state_d  = ST_SYNC;
          cnt_d    = '0;
          stages_d = '1;
          done_d   = 1'b0;
          ack_d    = 1'b0;
        end
      endcase
    end
  end

  // Sequencer registers; rst_i forces every stage into reset with no clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_SYNC;
      cnt_q    <= '0;
      stages_q <= '1;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stages_q <= stages_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
    end
  end

  // All outputs come straight from flops: no input reaches them combinationally.
  assign rst_o          = stages_q;
  assign done_o         = done_q;
  assign soft_rst_ack_o = ack_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_sico_reset_seq.sv
// tb_sico_reset_seq: self-checking bench for sico_reset_seq.
// Instance dut uses the default parameters; dut_min uses 1 stage, delay 1,
// synchronizer depth 4.
module tb_sico_reset_seq;

  localparam int N = 4;
  localparam int D = 16;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic         ack;
  logic [N-1:0] ro;
  logic         done;
  logic [1:0]   st;

  // Minimal instance
  logic         rst1 = 1'b1;
  logic         req1 = 1'b0;
  logic         ack1;
  logic [0:0]   ro1;
  logic         done1;
  logic [1:0]   st1;

  int total = 0;
  int bad   = 0;

  sico_reset_seq #(.NUM_STAGES(N), .STAGE_DELAY(D), .SYNC_DEPTH(S)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .soft_rst_req_i (req),
    .soft_rst_ack_o (ack),
    .rst_o          (ro),
    .done_o         (done),
    .state_o        (st)
  );

  sico_reset_seq #(.NUM_STAGES(1), .STAGE_DELAY(1), .SYNC_DEPTH(4)) dut_min (
    .clk_i          (clk),
    .rst_i          (rst1),
    .soft_rst_req_i (req1),
    .soft_rst_ack_o (ack1),
    .rst_o          (ro1),
    .done_o         (done1),
    .state_o        (st1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks which phase the sequencer is in and how many cycles
  // have passed since the release phase began; outputs follow from the rules.
  // ---------------------------------------------------------------------------
  typedef enum int {M_SYNC = 0, M_REL = 1, M_RUN = 2, M_SOFT = 3} mphase_t;
  mphase_t m_phase = M_SYNC;
  int      m_t     = 0;
  int      m_sync  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= M_SYNC;
      m_t     <= 0;
      m_sync  <= 0;
    end else begin
      case (m_phase)
        M_SYNC: begin
          m_sync <= m_sync + 1;
          if (m_sync + 1 == S) begin
            m_phase <= M_REL;
            m_t     <= 0;
          end
        end
        M_REL: begin
          m_t <= m_t + 1;
          if (m_t + 1 == N * D) m_phase <= M_RUN;
        end
        M_RUN:  if (req) m_phase <= M_SOFT;
        M_SOFT: if (!req) begin
          m_phase <= M_REL;
          m_t     <= 0;
        end
        default: m_phase <= M_SYNC;
      endcase
    end
  end

  function automatic logic [31:0] exp_rst_o();
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      r[k] = rst || (m_phase == M_SYNC) || (m_phase == M_SOFT) ||
             ((m_phase == M_REL) && (m_t < (k + 1) * D));
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_state();
    return rst ? 32'd0 : 32'(m_phase);
  endfunction

  // ---------------------------------------------------------------------------
  // Invariants on both instances every cycle: stage k+1 never out of reset
  // while stage k is held, and acknowledge only in SOFT.
  // ---------------------------------------------------------------------------
  function automatic bit order_ok(input logic [N-1:0] r);
    for (int k = 0; k < N - 1; k++) begin
      if (r[k] && !r[k+1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    total++;
    assert (order_ok(ro) && (st == 2'd3 || !ack) && (st1 == 2'd3 || !ack1))
    else begin
      bad++;
      $display("FAIL invariant: rst_o=%b ack=%b state=%0d ack_min=%b state_min=%0d",
               ro, ack, st, ack1, st1);
    end
  end

  // ---------------------------------------------------------------------------
  // Release timing table, relative to the cycle RELEASE was entered.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         cyc;
    logic [3:0] rst_o;
    logic       done;
    logic [1:0] state;
  } rel_vec_t;

  rel_vec_t rel_tab[10];

  typedef struct {
    logic       rst_o;
    logic       done;
    logic [1:0] state;
  } min_vec_t;

  min_vec_t min_tab[5];

  // Called at the sampling point of release cycle 0.
  task automatic run_release_table(input string tag);
    int now;
    now = 0;
    for (int i = 0; i < 10; i++) begin
      step(rel_tab[i].cyc - now);
      now = rel_tab[i].cyc;
      check($sformatf("%s_rst_o_c%0d", tag, now), 32'(ro),   32'(rel_tab[i].rst_o));
      check($sformatf("%s_done_c%0d",  tag, now), 32'(done), 32'(rel_tab[i].done));
      check($sformatf("%s_state_c%0d", tag, now), 32'(st),   32'(rel_tab[i].state));
      check($sformatf("%s_ack_c%0d",   tag, now), 32'(ack),  32'd0);
    end
  endtask

  // Global bound on the run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int rst_hold;

    rel_tab[0] = '{cyc: 0,  rst_o: 4'b1111, done: 1'b0, state: 2'd1};
    rel_tab[1] = '{cyc: 1,  rst_o: 4'b1111, done: 1'b0, state: 2'd1};
    rel_tab[2] = '{cyc: 15, rst_o: 4'b1111, done: 1'b0, state: 2'd1};
    rel_tab[3] = '{cyc: 16, rst_o: 4'b1110, done: 1'b0, state: 2'd1};
    rel_tab[4] = '{cyc: 31, rst_o: 4'b1110, done: 1'b0, state: 2'd1};
    rel_tab[5] = '{cyc: 32, rst_o: 4'b1100, done: 1'b0, state: 2'd1};
    rel_tab[6] = '{cyc: 47, rst_o: 4'b1100, done: 1'b0, state: 2'd1};
    rel_tab[7] = '{cyc: 48, rst_o: 4'b1000, done: 1'b0, state: 2'd1};
    rel_tab[8] = '{cyc: 63, rst_o: 4'b1000, done: 1'b0, state: 2'd1};
    rel_tab[9] = '{cyc: 64, rst_o: 4'b0000, done: 1'b1, state: 2'd2};

    // Edges 1..5 after rst_i falls on the minimal instance.
    min_tab[0] = '{rst_o: 1'b1, done: 1'b0, state: 2'd0};
    min_tab[1] = '{rst_o: 1'b1, done: 1'b0, state: 2'd0};
    min_tab[2] = '{rst_o: 1'b1, done: 1'b0, state: 2'd0};
    min_tab[3] = '{rst_o: 1'b1, done: 1'b0, state: 2'd1};
    min_tab[4] = '{rst_o: 1'b0, done: 1'b1, state: 2'd2};

    // Reset state of both instances
    step(3);
    check("reset_rst_o",     32'(ro),    32'hF);
    check("reset_done",      32'(done),  32'd0);
    check("reset_ack",       32'(ack),   32'd0);
    check("reset_state",     32'(st),    32'd0);
    check("reset_min_rst_o", 32'(ro1),   32'd1);
    check("reset_min_state", 32'(st1),   32'd0);

    // Boot: rst_i falls between edges; RELEASE after the 2nd edge
    rst = 1'b0;
    step(1);
    check("boot_state_e1", 32'(st), 32'd0);
    check("boot_rst_o_e1", 32'(ro), 32'hF);
    step(1);
    check("boot_state_e2", 32'(st), 32'd1);
    run_release_table("boot");

    // Soft reset held 10 cycles from RUN
    req = 1'b1;
    step(1);
    check("soft_rst_o", 32'(ro),   32'hF);
    check("soft_ack",   32'(ack),  32'd1);
    check("soft_state", 32'(st),   32'd3);
    check("soft_done",  32'(done), 32'd0);
    step(9);
    check("soft_hold_ack",   32'(ack), 32'd1);
    check("soft_hold_state", 32'(st),  32'd3);
    req = 1'b0;
    step(1);
    check("soft_drop_ack",   32'(ack), 32'd0);
    check("soft_drop_state", 32'(st),  32'd1);
    run_release_table("soft");

    // Hard reset in the middle of RELEASE, then full restart
    req = 1'b1;
    step(1);
    req = 1'b0;
    step(1);
    check("mid_rel_entry", 32'(st), 32'd1);
    step(40);
    check("mid_rst_o_c40", 32'(ro), 32'hC);
    #2 rst = 1'b1;
    #1;
    check("mid_async_rst_o", 32'(ro),   32'hF);
    check("mid_async_state", 32'(st),   32'd0);
    check("mid_async_done",  32'(done), 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    check("restart_state_e1", 32'(st), 32'd0);
    step(1);
    check("restart_state_e2", 32'(st), 32'd1);
    run_release_table("restart");

    // Request raised during RELEASE is held off until RUN
    req = 1'b1;
    step(1);
    req = 1'b0;
    step(1);
    step(5);
    req = 1'b1;
    n = 0;
    while (!done && n < 200) begin
      check("early_req_ack",   32'(ack), 32'd0);
      check("early_req_state", 32'(st),  32'd1);
      step(1);
      n++;
    end
    check("early_req_wait_cycles", 32'(n), 32'd59);
    check("early_req_run_state",   32'(st),  32'd2);
    check("early_req_run_ack",     32'(ack), 32'd0);
    step(1);
    check("early_req_soft_state", 32'(st),  32'd3);
    check("early_req_soft_ack",   32'(ack), 32'd1);
    check("early_req_soft_rst_o", 32'(ro),  32'hF);
    req = 1'b0;
    step(1);
    check("early_req_end_ack",   32'(ack), 32'd0);
    check("early_req_end_state", 32'(st),  32'd1);

    // Minimal configuration: depth-4 synchronizer, one stage, delay 1
    rst1 = 1'b0;
    for (int e = 0; e < 5; e++) begin
      step(1);
      check($sformatf("min_rst_o_e%0d", e + 1), 32'(ro1),   32'(min_tab[e].rst_o));
      check($sformatf("min_done_e%0d",  e + 1), 32'(done1), 32'(min_tab[e].done));
      check($sformatf("min_state_e%0d", e + 1), 32'(st1),   32'(min_tab[e].state));
    end

    // Randomized soft requests and hard reset pulses against the model
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      check("rnd_rst_o", 32'(ro),   exp_rst_o());
      check("rnd_state", 32'(st),   exp_state());
      check("rnd_done",  32'(done), 32'((!rst) && (m_phase == M_RUN)));
      check("rnd_ack",   32'(ack),  32'((!rst) && (m_phase == M_SOFT)));
      if (rst) begin
        if (rst_hold == 0) rst = 1'b0;
        else rst_hold--;
      end else if ($urandom_range(0, 399) == 0) begin
        rst      = 1'b1;
        rst_hold = int'($urandom_range(0, 2));
      end
      if ($urandom_range(0, 39) == 0) req = ~req;
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sico_reset_seq.md
SICO_RESET_SEQ -- requirements
Module: sico_reset_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: number of sequenced reset domains, range 1..8.
REQ-002 SHALL have parameter STAGE_DELAY, default 16: clk_i cycles between consecutive stage releases, range 1..65535.
REQ-003 SHALL have parameter SYNC_DEPTH, default 2: reset-deassertion synchronizer flops, range 2..4.
REQ-004 SHALL have port clk_i  input  1  system clock, sourced by the simulation clock/reset controller.
REQ-005 SHALL have port rst_i  input  1  reset; asynchronous, active-high; one clock domain (clk_i) only.
REQ-006 SHALL have port soft_rst_req_i  input  1  soft-reset request, four-phase level handshake.
REQ-007 SHALL have port soft_rst_ack_o  output  1  soft-reset acknowledge.
REQ-008 SHALL have port rst_o  output  NUM_STAGES  per-stage active-high reset; bit k is stage k.
REQ-009 SHALL have port done_o  output  1  high when all stages are released.
REQ-010 SHALL have port state_o  output  2  current state: 0 SYNC, 1 RELEASE, 2 RUN, 3 SOFT.

Function
REQ-011 SHALL assert all rst_o bits asynchronously and immediately whenever rst_i is high.
REQ-012 SHALL pass rst_i deassertion through a SYNC_DEPTH-flop synchronizer that presets asynchronously when rst_i is high.
REQ-013 SHALL stay in SYNC while the synchronizer output is high and move to RELEASE on the first clk_i edge at which it is low.
REQ-014 SHALL clear the delay counter to 0 on entering RELEASE and increment it by 1 per cycle in RELEASE.
REQ-015 SHALL deassert rst_o[k] exactly (k+1)*STAGE_DELAY cycles after entering RELEASE, in ascending k order, one stage per release.
REQ-016 SHALL never deassert rst_o[k+1] while rst_o[k] is asserted.
REQ-017 SHALL enter RUN and raise done_o in the same cycle that rst_o[NUM_STAGES-1] deasserts.
REQ-018 SHALL size the delay counter to hold STAGE_DELAY without wrap; it resets to 0 after each stage release.
REQ-019 SHALL sample soft_rst_req_i only in RUN; requests raised in SYNC or RELEASE are held off until RUN is reached.
REQ-020 SHALL, in RUN with soft_rst_req_i high, move to SOFT on the next edge: all rst_o high, done_o low, soft_rst_ack_o high, all registered in that same edge.
REQ-021 SHALL hold SOFT while soft_rst_req_i is high; on the first edge where it is low, SHALL drop soft_rst_ack_o and enter RELEASE with the counter cleared.
REQ-022 SHALL keep soft_rst_ack_o low in every state except SOFT.
REQ-023 SHALL, on rst_i asserting in any state (including mid-RELEASE or SOFT), abandon the sequence and restart from SYNC after deassertion.
REQ-024 SHALL drive state_o directly from the state register, with no combinational path from inputs.

Reset
REQ-025 SHALL, while rst_i is high, hold: rst_o all ones, done_o 0, soft_rst_ack_o 0, state_o 0 (SYNC), counter 0, synchronizer all ones.
REQ-026 SHALL use asynchronous active-high reset on every flop in the block.
REQ-027 SHALL leave rst_o deassertion synchronous to the rising edge of clk_i only.

Verification
REQ-028 Defaults; rst_i falls between edges -> state_o becomes 1 after the 2nd edge, rst_o = 4'b1110/1100/1000/0000 at 16/32/48/64 cycles after RELEASE entry, done_o=1 at 64.
REQ-029 Defaults; in RUN raise soft_rst_req_i for 10 cycles -> next edge rst_o=4'b1111, ack=1, state_o=3; ack falls 1 edge after req falls; re-release at 16/32/48/64 cycles.
REQ-030 Defaults; pulse rst_i at cycle 40 of RELEASE (rst_o=4'b1100) -> rst_o=4'b1111 with no clock edge; the full sequence restarts from SYNC.
REQ-031 Defaults; raise soft_rst_req_i during RELEASE -> no ack and no effect until done_o=1; SOFT is entered 1 edge after RUN.
REQ-032 NUM_STAGES=1, STAGE_DELAY=1, SYNC_DEPTH=4 -> after rst_i falls, RELEASE starts after the 4th edge; rst_o=0 and done_o=1 one cycle later.
REQ-033 Throughout all scenarios, an assertion checks REQ-016 ordering and ack=0 outside SOFT.
